sync_fifo: RTL and testbench
============================

// Module: sync_fifo
// PURPOSE
//  Single-clock first-in/first-out buffer of DEPTH words of WIDTH bits.
//  Decouples a producer and a consumer that share clk_i.
//  Reports full/empty status and flags rejected writes (overflow) and rejected reads (underflow).
//  Generic datapath buffer; no handshake beyond the enables and status flags.
// PARAMETERS
//  DEPTH      16  number of storage entries; must be a power of two and equal 2**PTR_WIDTH
//  WIDTH      8   data word width in bits
//  PTR_WIDTH  4   address width; internal pointers carry one extra wrap bit (PTR_WIDTH+1)
// PORTS
//  clk_i       in   1          single clock, rising edge
//  rst_i       in   1          reset, asynchronous, active-high
//  wdata_i     in   WIDTH      write data, sampled when a write is accepted
//  full_o      out  1          FIFO holds DEPTH words
//  wr_en_i     in   1          write request
//  wr_error_o  out  1          previous cycle's write was rejected (FIFO full)
//  rdata_o     out  WIDTH      read data, registered
//  empty_o     out  1          FIFO holds zero words
//  rd_en_i     in   1          read request
//  rd_error_o  out  1          previous cycle's read was rejected (FIFO empty)
// BEHAVIOUR
//  - Reset (async assert, sync release at rising edge):
//    - wr_ptr=0, rd_ptr=0, rdata_o=0, empty_o=1, full_o=0, wr_error_o=0, rd_error_o=0.
//    - Storage array is not reset.
//  - Accepted write: wr_en_i=1 and full_o=0 at the edge -> mem[wr_ptr]<=wdata_i; wr_ptr increments.
//  - Accepted read: rd_en_i=1 and empty_o=0 at the edge -> rdata_o<=mem[rd_ptr]; rd_ptr increments.
//    - Latency: one cycle; rdata_o holds its value when no read is accepted.
//  - Rejected write: wr_en_i=1 and full_o=1 -> no state change; wr_error_o=1 for the following cycle.
//  - Rejected read: rd_en_i=1 and empty_o=1 -> rdata_o unchanged; rd_error_o=1 for the following cycle.
//  - Error flags are registered and recomputed every edge (pulse, not sticky).
//  - Status flags are combinational from the pointers:
//    - empty_o = (wr_ptr == rd_ptr).
//    - full_o  = (addr bits equal) && (wrap bits differ).
//  - Pointers wrap modulo 2*DEPTH; the address is ptr[PTR_WIDTH-1:0].
//  - Simultaneous rd_en_i & wr_en_i:
//    - Neither full nor empty: both occur; occupancy unchanged.
//    - When full: read accepted, write rejected (flags use pre-edge state).
//    - When empty: write accepted, read rejected.
//  - Reset mid-operation: all contents discarded immediately; FIFO returns to empty.
// CONFIGURATION
//  SYNC_FIFO_COUNT_EN defined:
//    - Adds output count_o [PTR_WIDTH:0] = wr_ptr - rd_ptr, range 0..DEPTH.
//    - count_o is 0 in reset.
//  SYNC_FIFO_COUNT_EN undefined: count_o port and its logic are absent; all else identical.
// STRUCTURE
//  - Package sync_fifo_pkg: default DEPTH/WIDTH/PTR_WIDTH localparams.
//  - Package also provides ptr_t typedef (logic [PTR_WIDTH:0]).
//  - Sub-module sync_fifo_mem: DEPTH x WIDTH array.
//    - Synchronous write port; read registered into rdata_o by the parent.
//  - Top holds pointers, flags, error registers and optional count.
// TESTING
//  1. Reset, rd_en_i=wr_en_i=0 -> empty_o=1, full_o=0, rdata_o=0, both errors 0.
//  2. 16 consecutive writes of 0x00..0x0F:
//     - After the 16th write, full_o=1; empty_o falls after the 1st write.
//  3. Then 16 consecutive reads:
//     - rdata_o = 0x00..0x0F in order, each one cycle after its read.
//     - empty_o=1 after the last read.
//  4. Write 0xAA while full -> wr_error_o=1 for one cycle, contents unchanged.
//     Read while empty -> rd_error_o=1, rdata_o held.
//  5. Fill 8, then 20 cycles of simultaneous rd/wr -> occupancy stays 8; order preserved across pointer wrap.
//  6. Assert rst_i mid-stream with 5 entries -> flags return to reset values immediately.
//     With SYNC_FIFO_COUNT_EN, count_o tracks 0..16 throughout.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared defaults and pointer type for sync_fifo.
// Provides DEF_DEPTH/DEF_WIDTH/DEF_PTR_WIDTH and ptr_t (address + wrap bit).
package sync_fifo_pkg;

    localparam int DEF_DEPTH     = 16;
    localparam int DEF_WIDTH     = 8;
    localparam int DEF_PTR_WIDTH = 4;

    typedef logic [DEF_PTR_WIDTH:0] ptr_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: DEPTH x WIDTH storage, synchronous write, async read.
// Ports: clk_i, we_i, waddr_i, wdata_i, raddr_i, rdata_o (unregistered).
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH     = DEF_DEPTH,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int PTR_WIDTH = DEF_PTR_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [PTR_WIDTH-1:0] waddr_i,
    input  logic [WIDTH-1:0]     wdata_i,
    input  logic [PTR_WIDTH-1:0] raddr_i,
    output logic [WIDTH-1:0]     rdata_o
);

    // Storage is deliberately left unreset.
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with full/empty status and error pulses.
// Ports: clk_i, rst_i (async high), wdata_i/wr_en_i/full_o/wr_error_o,
// rdata_o/rd_en_i/empty_o/rd_error_o; count_o when SYNC_FIFO_COUNT_EN.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH     = DEF_DEPTH,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int PTR_WIDTH = DEF_PTR_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             full_o,
    input  logic             wr_en_i,
    output logic             wr_error_o,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    input  logic             rd_en_i,
    output logic             rd_error_o
`ifdef SYNC_FIFO_COUNT_EN
   ,output logic [PTR_WIDTH:0] count_o
`endif
);

    logic [PTR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0]   rdata_q, rdata_d;
    logic               wr_err_q, wr_err_d;
    logic               rd_err_q, rd_err_d;
    logic [WIDTH-1:0]   mem_rdata;
    logic               wr_acc;
    logic               rd_acc;

    // Extra MSB distinguishes full from empty when addresses coincide.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PTR_WIDTH-1:0] == rd_ptr_q[PTR_WIDTH-1:0])
                  && (wr_ptr_q[PTR_WIDTH] != rd_ptr_q[PTR_WIDTH]);

    assign wr_acc = wr_en_i && !full_o;
    assign rd_acc = rd_en_i && !empty_o;

    sync_fifo_mem #(
        .DEPTH     (DEPTH),
        .WIDTH     (WIDTH),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q[PTR_WIDTH-1:0]),
        .wdata_i (wdata_i),
        .raddr_i (rd_ptr_q[PTR_WIDTH-1:0]),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        rdata_d  = rdata_q;
        wr_err_d = wr_en_i && full_o;
        rd_err_d = rd_en_i && empty_o;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            rdata_d  = mem_rdata;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rdata_q  <= '0;
            wr_err_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            rdata_q  <= rdata_d;
            wr_err_q <= wr_err_d;
            rd_err_q <= rd_err_d;
        end
    end

    assign rdata_o    = rdata_q;
    assign wr_error_o = wr_err_q;
    assign rd_error_o = rd_err_q;

`ifdef SYNC_FIFO_COUNT_EN
    // Modular difference gives 0..DEPTH thanks to the wrap bit.
    assign count_o = wr_ptr_q - rd_ptr_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: randomized self-checking bench for sync_fifo.
// Reference model is a queue; define SYNC_FIFO_COUNT_EN to check count_o.
module tb_sync_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] wdata = '0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic       full, empty, wr_err, rd_err;
    logic [7:0] rdata;
`ifdef SYNC_FIFO_COUNT_EN
    logic [4:0] count;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    logic [7:0] m_rdata = '0;
    logic       m_wr_err = 1'b0;
    logic       m_rd_err = 1'b0;

    always #5 clk = ~clk;

    sync_fifo dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .wdata_i    (wdata),
        .full_o     (full),
        .wr_en_i    (wr_en),
        .wr_error_o (wr_err),
        .rdata_o    (rdata),
        .empty_o    (empty),
        .rd_en_i    (rd_en),
        .rd_error_o (rd_err)
`ifdef SYNC_FIFO_COUNT_EN
       ,.count_o    (count)
`endif
    );

    task automatic model_reset();
        q.delete();
        m_rdata  = '0;
        m_wr_err = 1'b0;
        m_rd_err = 1'b0;
    endtask

    // Drive one cycle and advance the model from the pre-edge occupancy.
    task automatic step(input bit we, input bit re, input logic [7:0] d);
        bit f, e;
        f = (q.size() == 16);
        e = (q.size() == 0);
        wr_en = we;
        rd_en = re;
        wdata = d;
        @(posedge clk);
        m_wr_err = we && f;
        m_rd_err = re && e;
        if (re && !e) m_rdata = q.pop_front();
        if (we && !f) q.push_back(d);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b0, 1'b0, 8'h00);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h exp 00", rdata); end
        checks++; if (wr_err !== 1'b0 || rd_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b%b exp 00", wr_err, rd_err); end
`ifdef SYNC_FIFO_COUNT_EN
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
`endif
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 8'(i));
            checks++; if (empty !== 1'b0) begin errors++; $display("FAIL fill_empty i=%0d got %b exp 0", i, empty); end
            checks++; if (full !== (i == 15)) begin errors++; $display("FAIL fill_full i=%0d got %b exp %b", i, full, i == 15); end
`ifdef SYNC_FIFO_COUNT_EN
            checks++; if (count !== 5'(i + 1)) begin errors++; $display("FAIL fill_count got %0d exp %0d", count, i + 1); end
`endif
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 8'h00);
            checks++; if (rdata !== 8'(i)) begin errors++; $display("FAIL drain_data i=%0d got %h exp %h", i, rdata, 8'(i)); end
            checks++; if (full !== 1'b0) begin errors++; $display("FAIL drain_full got %b exp 0", full); end
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b exp 1", empty); end
    endtask

    task automatic test_errors();
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'($urandom));
        step(1'b1, 1'b0, 8'hAA);
        checks++; if (wr_err !== 1'b1) begin errors++; $display("FAIL wr_err_set got %b exp 1", wr_err); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL wr_err_full got %b exp 1", full); end
        step(1'b0, 1'b0, 8'h00);
        checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL wr_err_pulse got %b exp 0", wr_err); end
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 8'h00);
            checks++; if (rdata !== m_rdata) begin errors++; $display("FAIL err_contents i=%0d got %h exp %h", i, rdata, m_rdata); end
        end
        step(1'b0, 1'b1, 8'h00);
        checks++; if (rd_err !== 1'b1) begin errors++; $display("FAIL rd_err_set got %b exp 1", rd_err); end
        checks++; if (rdata !== m_rdata) begin errors++; $display("FAIL rd_err_hold got %h exp %h", rdata, m_rdata); end
        step(1'b0, 1'b0, 8'h00);
        checks++; if (rd_err !== 1'b0) begin errors++; $display("FAIL rd_err_pulse got %b exp 0", rd_err); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'($urandom));
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 8'($urandom));
            checks++; if (rdata !== m_rdata) begin errors++; $display("FAIL b2b_data i=%0d got %h exp %h", i, rdata, m_rdata); end
            checks++; if (empty !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL b2b_flags got e%b f%b exp e0 f0", empty, full); end
`ifdef SYNC_FIFO_COUNT_EN
            checks++; if (count !== 5'd8) begin errors++; $display("FAIL b2b_count got %0d exp 8", count); end
`endif
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 8'h00);
            checks++; if (rdata !== m_rdata) begin errors++; $display("FAIL b2b_drain i=%0d got %h exp %h", i, rdata, m_rdata); end
        end
    endtask

    task automatic test_random();
        int bias;
        for (int i = 0; i < 400; i++) begin
            bias = (i / 50) % 2 == 0 ? 75 : 25;
            step(($urandom_range(99) < bias), ($urandom_range(99) >= bias),
                 8'($urandom));
            checks++;
            if (rdata !== m_rdata || empty !== (q.size() == 0)
                || full !== (q.size() == 16) || wr_err !== m_wr_err
                || rd_err !== m_rd_err) begin
                errors++;
                $display("FAIL rand i=%0d got d%h e%b f%b we%b re%b exp d%h e%b f%b we%b re%b",
                         i, rdata, empty, full, wr_err, rd_err, m_rdata,
                         q.size() == 0, q.size() == 16, m_wr_err, m_rd_err);
            end
`ifdef SYNC_FIFO_COUNT_EN
            checks++; if (count !== 5'(q.size())) begin errors++; $display("FAIL rand_count got %0d exp %0d", count, q.size()); end
`endif
        end
    endtask

    task automatic test_mid_reset();
        while (q.size() > 0) step(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'($urandom));
        step(1'b1, 1'b1, 8'h5A);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL mrst_flags got e%b f%b exp e1 f0", empty, full); end
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL mrst_rdata got %h exp 00", rdata); end
        checks++; if (wr_err !== 1'b0 || rd_err !== 1'b0) begin errors++; $display("FAIL mrst_err got %b%b exp 00", wr_err, rd_err); end
`ifdef SYNC_FIFO_COUNT_EN
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL mrst_count got %0d exp 0", count); end
`endif
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b1, 8'h00);
        checks++; if (rd_err !== 1'b1 || rdata !== 8'h00) begin errors++; $display("FAIL mrst_read got err%b d%h exp err1 d00", rd_err, rdata); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_errors();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
